mixcol_seq: RTL and testbench
=============================

Name: mixcol_seq

Overview:
- Sequences one shared 32-bit MixColumns word datapath (`mixw`) across the four columns of a 128-bit AES state, one column per clock.
- Provides a valid/ready handshake on both sides, a final-round bypass and a synchronous flush.
- Sits between the AES round-key/shift stage and AddRoundKey in the round pipeline. It trades 4 cycles of latency for a single `mixw` instance instead of four.

Parameters:
- NCOL, 4, number of 32-bit columns per state; fixed at 4 for AES-128/192/256. Any other value is unsupported.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- flush  input  1  synchronous abort; returns block to IDLE
- in_valid  input  1  in_state and in_bypass are valid
- in_ready  output  1  block can accept a state this cycle
- in_state  input  128  AES state; column c = in_state[127-32c -: 32], byte order {s0c,s1c,s2c,s3c}
- in_bypass  input  1  1 = final round, pass state through unmixed
- out_valid  output  1  out_state is valid
- out_ready  input  1  downstream accepts out_state
- out_state  output  128  mixed (or bypassed) state, same column layout as in_state
- busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (rst=1, async):
  - state=IDLE, col_cnt=0, work register=0.
  - Outputs: in_ready=1, out_valid=0, out_state=0, busy=0.
- FSM states: IDLE, MIX, DONE.
- IDLE:
  - in_ready=1.
  - Accept on in_valid&in_ready: latch in_state into the work register and in_bypass into a flag.
  - bypass=0 -> MIX, col_cnt=0. bypass=1 -> DONE.
- MIX:
  - in_ready=0.
  - Each cycle, word col_cnt of the work register drives `mixw`. Its output is written back to the same word at the edge, and col_cnt increments.
  - When col_cnt==NCOL-1 is written: -> DONE, col_cnt wraps to 0.
  - Exactly 4 MIX cycles; each column is processed exactly once.
- DONE:
  - out_valid=1, out_state=work register, held stable until out_ready.
  - On out_valid&out_ready: -> IDLE.
  - No new accept in DONE, even when out_ready=1 in the same cycle (in_ready=0 in DONE).
- Latency, measured from the accept edge to the first cycle with out_valid=1:
  - Mix: 5 cycles (4 MIX + transition).
  - Bypass: 1 cycle.
- Throughput: one state per 6 cycles (mix) or 2 cycles (bypass) with out_ready held high.
- out_state:
  - Reflects the work register only when out_valid=1.
  - Its value while out_valid=0 is don't-care for checking, but must not glitch in DONE.
- Flush:
  - When flush=1 at an edge, in any state: -> IDLE, col_cnt=0, out_valid=0 next cycle. The work register is left unchanged.
  - flush overrides a concurrent accept; the presented input is not accepted.
  - flush overrides a concurrent out handshake; the transfer is considered not to have occurred.
- Reset mid-operation: immediate async return to the reset values; the partial state is discarded.
- in_state/in_bypass are sampled only at the accept edge; later changes are ignored.
- Arithmetic lives entirely in `mixw` (GF(2^8), poly 0x11B). The controller performs no arithmetic besides the 2-bit col_cnt, which wraps modulo 4.
- busy = (state != IDLE).

Test Plan:
- FIPS-197 vector:
  - Stimulus: in_state=db135345_f20a225c_01010101_c6c6c6c6, bypass=0, out_ready=1.
  - Required: out_state=8e4da1bc_9fdc589d_01010101_c6c6c6c6; out_valid rises exactly 5 cycles after accept; busy high for 5 cycles.
- Second vector with backpressure:
  - Stimulus: in_state=d4d4d4d5_2d26314c_00000000_ffffffff, out_ready=0 for 10 cycles, then 1.
  - Required: out_state=d5d5d7d6_4d7ebdf8_00000000_ffffffff, held stable throughout; in_ready=0 until the cycle after the handshake.
- Bypass:
  - Stimulus: in_state=00112233_44556677_8899aabb_ccddeeff, bypass=1.
  - Required: identical out_state; out_valid rises 1 cycle after accept; col_cnt stays 0.
- Flush in MIX:
  - Stimulus: assert flush on the 2nd MIX cycle.
  - Required: busy=0 and in_ready=1 next cycle, and out_valid never rises. A following vector 1 then produces the correct result.
- Async reset in DONE:
  - Stimulus: assert rst between clock edges while out_valid=1.
  - Required: out_valid=0, out_state=0, in_ready=1 immediately without a clock edge; normal operation after release.
- Back-to-back with in_valid held high and out_ready=1:
  - Stimulus: two vectors presented back-to-back.
  - Required: second accept occurs exactly 6 cycles after the first; in_ready=0 in DONE; both results correct and in order.

Source files
------------

// File: rtl/mixcol_seq.sv
// Runs one shared MixColumns word datapath over the four AES columns, one column per clock.
// Latency 5 cycles accept-to-out_valid (1 on bypass); holds the result in DONE until out_ready.

module mixw (
  input  logic [31:0] col,
  output logic [31:0] mixed
);
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0] s0, s1, s2, s3;

  always_comb begin
    s0 = col[31:24];
    s1 = col[23:16];
    s2 = col[15:8];
    s3 = col[7:0];
    mixed = {xt(s0) ^ xt(s1) ^ s1 ^ s2 ^ s3,
             s0 ^ xt(s1) ^ xt(s2) ^ s2 ^ s3,
             s0 ^ s1 ^ xt(s2) ^ xt(s3) ^ s3,
             xt(s0) ^ s0 ^ s1 ^ s2 ^ xt(s3)};
  end
endmodule

module mixcol_seq #(
  parameter int NCOL = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_bypass,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, MIX, DONE} state_t;

  state_t                 state, state_nx;
  logic [1:0]             col_cnt;
  logic [NCOL-1:0][31:0]  work;
  logic [1:0]             widx;
  logic [31:0]            mix_in, mix_out;
  logic                   accept, mix_en;

  // Column 0 sits in the most significant word, so the packed index runs opposite to col_cnt.
  assign widx   = 2'(NCOL - 1) - col_cnt;
  assign mix_in = work[widx];

  mixw u_mixw (
    .col   (mix_in),
    .mixed (mix_out)
  );

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    mix_en    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept   = 1'b1;
          state_nx = in_bypass ? DONE : MIX;
        end
      end
      MIX: begin
        mix_en = 1'b1;
        if (col_cnt == 2'(NCOL - 1)) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // Flush wins over any handshake happening on the same edge.
    if (flush) begin
      state_nx = IDLE;
      accept   = 1'b0;
      mix_en   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  col_cnt <= 2'd0;
    else if (flush || accept) col_cnt <= 2'd0;
    else if (mix_en)          col_cnt <= col_cnt + 2'd1;
  end

  // Flush deliberately leaves the work register alone; only the state is abandoned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         work       <= '0;
    else if (accept) work       <= in_state;
    else if (mix_en) work[widx] <= mix_out;
  end

  assign out_state = work;
  assign busy      = (state != IDLE);
endmodule

// File: tb/tb_mixcol_seq.sv
// Bench for mixcol_seq: vector table plus hand sequences for backpressure, flush, reset and back-to-back.
module tb_mixcol_seq;
  logic         clk = 1'b0;
  logic         rst, flush, in_valid, in_ready, in_bypass, out_valid, out_ready, busy;
  logic [127:0] in_state, out_state;

  mixcol_seq #(.NCOL(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_state(in_state), .in_bypass(in_bypass), .out_valid(out_valid),
    .out_ready(out_ready), .out_state(out_state), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] st;
    logic         byp;
    logic [127:0] exp;
  } vec_t;

  typedef struct {
    logic [127:0] exp;
    logic         byp;
    int           acc;
  } sb_t;

  vec_t         tbl [7];
  sb_t          sb [$];
  int           n_vec = 0, n_err = 0, cyc = 0;
  logic [127:0] cur_exp = '0;
  logic         cur_byp = 1'b0;
  bit           hs_prev = 0, ov_prev = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: event did not occur within its cycle budget", name);
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s);
    logic [127:0] r = '0;
    logic [7:0]   pat [4];
    logic [7:0]   b [4];
    logic [7:0]   acc;
    pat[0] = 8'h02; pat[1] = 8'h03; pat[2] = 8'h01; pat[3] = 8'h01;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) b[k] = s[127 - 32*c - 8*k -: 8];
      for (int k = 0; k < 4; k++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(pat[(j - k) & 3], b[j]);
        r[127 - 32*c - 8*k -: 8] = acc;
      end
    end
    return r;
  endfunction

  // Monitor: scoreboard push on accept, pop on output handshake, protocol checks every cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (hs_prev) check("in_ready_after_hs", 128'(in_ready), 128'd1);
      hs_prev = 0;
      if (busy) check("in_ready_low_when_busy", 128'(in_ready), 128'd0);
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_out_valid", 128'(out_valid), 128'd0);
        end else begin
          if (!ov_prev)
            check_int("latency", cyc - sb[0].acc, sb[0].byp ? 1 : 5);
          check("out_state", out_state, sb[0].exp);
          if (out_ready && !flush) begin
            void'(sb.pop_front());
            hs_prev = 1;
          end
        end
      end
      if (flush) sb.delete();
      if (in_valid && in_ready && !flush) sb.push_back('{cur_exp, cur_byp, cyc});
      ov_prev = out_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input vec_t v, input bit keep, output int acc);
    in_valid  = 1'b1;
    in_state  = v.st;
    in_bypass = v.byp;
    cur_exp   = v.exp;
    cur_byp   = v.byp;
    acc       = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready && !flush) begin
        acc = cyc;
        break;
      end
    end
    tick();
    if (acc < 0) fail("accept_timeout");
    if (!keep) begin
      in_valid  = 1'b0;
      in_state  = ~v.st;
      in_bypass = ~v.byp;
    end
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) begin
        done = 1;
        break;
      end
    end
    if (!done) fail("drain_timeout");
    tick();
  endtask

  initial begin
    int a0, a1, cnt;
    bit seen;

    tbl[0] = '{128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6};
    tbl[1] = '{128'hd4d4d4d5_2d26314c_00000000_ffffffff, 1'b0, 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff};
    tbl[2] = '{128'h00112233_44556677_8899aabb_ccddeeff, 1'b1, 128'h00112233_44556677_8899aabb_ccddeeff};
    tbl[3] = '{128'h0, 1'b0, 128'h0};
    for (int i = 4; i < 7; i++) begin
      tbl[i].st  = {$urandom, $urandom, $urandom, $urandom};
      tbl[i].byp = (i == 5);
      tbl[i].exp = tbl[i].byp ? tbl[i].st : model(tbl[i].st);
    end

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_bypass = 1'b0;
    in_state = '0; out_ready = 1'b1;
    #1;
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_out_state", out_state, 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // FIPS-197 column vector, with busy duration
    send(tbl[0], 0, a0);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (!busy) break;
      cnt++;
    end
    check_int("busy_cycles", cnt, 5);
    drain();

    foreach (tbl[i]) begin
      send(tbl[i], 0, a0);
      drain();
    end

    // Backpressure: result must hold across 10 stalled cycles
    out_ready = 1'b0;
    send(tbl[1], 0, a0);
    repeat (10) @(negedge clk);
    check("bp_out_valid", 128'(out_valid), 128'd1);
    tick();
    out_ready = 1'b1;
    drain();

    // Flush on the second MIX cycle
    send(tbl[0], 0, a0);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("flush_busy", 128'(busy), 128'd0);
    check("flush_in_ready", 128'(in_ready), 128'd1);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check("flush_no_out_valid", 128'(seen), 128'd0);
    tick();
    send(tbl[0], 0, a0);
    drain();

    // Async reset while holding a result in DONE
    out_ready = 1'b0;
    send(tbl[0], 0, a0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1;
        break;
      end
    end
    if (!seen) fail("reset_wait_out_valid");
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", 128'(out_valid), 128'd0);
    check("arst_out_state", out_state, 128'd0);
    check("arst_in_ready", 128'(in_ready), 128'd1);
    check("arst_busy", 128'(busy), 128'd0);
    sb.delete();
    hs_prev = 0;
    ov_prev = 0;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    send(tbl[1], 0, a0);
    drain();

    // Back-to-back with in_valid held high
    send(tbl[0], 1, a0);
    send(tbl[1], 0, a1);
    check_int("b2b_accept_spacing", a1 - a0, 6);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
